// File: rtl/eth_link_activity_led.sv
// rtl/eth_link_activity_led.sv - per-port link/activity LED controller
// Debounced link LED, fixed-rate activity blink, shared remote-fault flash and lamp test.
module eth_link_activity_led #(
  parameter int NUM_PORTS         = 2,
  parameter int BLINK_CYCLES      = 6250000,
  parameter int DEBOUNCE_CYCLES   = 1250000,
  parameter int FAULT_HALF_CYCLES = 31250000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] link_up,
  input  logic [NUM_PORTS-1:0] remote_fault,
  input  logic [NUM_PORTS-1:0] rx_activity,
  input  logic [NUM_PORTS-1:0] tx_activity,
  input  logic                 lamp_test,
  output logic [NUM_PORTS-1:0] led_link,
  output logic [NUM_PORTS-1:0] led_act
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam int FW = $clog2(FAULT_HALF_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [FW-1:0] FAULT_LAST = FW'(FAULT_HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    DOWN     = 3'd0,
    DEBOUNCE = 3'd1,
    IDLE     = 3'd2,
    ACT_ON   = 3'd3,
    ACT_OFF  = 3'd4
  } port_state_t;

  logic [FW-1:0] fault_cnt;
  logic          fault_phase;

  // One prescaler shared by all ports; remote_fault edges never resynchronise it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_cnt   <= '0;
      fault_phase <= 1'b0;
    end else if (fault_cnt == FAULT_LAST) begin
      fault_cnt   <= '0;
      fault_phase <= ~fault_phase;
    end else begin
      fault_cnt <= fault_cnt + FW'(1);
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_state_t   state;
    logic [DW-1:0] deb_cnt;
    logic [BW-1:0] blink_cnt;
    logic          pending;
    logic          activity;
    logic          linked;
    logic          link_q;
    logic          act_q;

    assign activity = rx_activity[p] | tx_activity[p];
    assign linked   = (state == IDLE) || (state == ACT_ON) || (state == ACT_OFF);

    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= DOWN;
        deb_cnt   <= '0;
        blink_cnt <= '0;
        pending   <= 1'b0;
        link_q    <= 1'b0;
        act_q     <= 1'b0;
      end else begin
        // LEDs follow the state held before this edge, so they trail it by one cycle.
        if (lamp_test) begin
          link_q <= 1'b1;
          act_q  <= 1'b1;
        end else begin
          link_q <= linked & (remote_fault[p] ? fault_phase : 1'b1);
          act_q  <= (state == ACT_ON);
        end

        if (!link_up[p]) begin
          state     <= DOWN;
          deb_cnt   <= '0;
          blink_cnt <= '0;
          pending   <= 1'b0;
        end else begin
          case (state)
            DOWN: begin
              state   <= DEBOUNCE;
              deb_cnt <= '0;
            end
            DEBOUNCE: begin
              if (deb_cnt == DEB_LAST) begin
                state   <= IDLE;
                deb_cnt <= '0;
              end else begin
                deb_cnt <= deb_cnt + DW'(1);
              end
            end
            IDLE: begin
              if (activity) begin
                state     <= ACT_ON;
                blink_cnt <= '0;
              end
            end
            ACT_ON: begin
              if (activity) pending <= 1'b1;
              if (blink_cnt == BLINK_LAST) begin
                state     <= ACT_OFF;
                blink_cnt <= '0;
              end else begin
                blink_cnt <= blink_cnt + BW'(1);
              end
            end
            ACT_OFF: begin
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                pending   <= 1'b0;
                state     <= (pending || activity) ? ACT_ON : IDLE;
              end else begin
                blink_cnt <= blink_cnt + BW'(1);
                if (activity) pending <= 1'b1;
              end
            end
            default: state <= DOWN;
          endcase
        end
      end
    end

    assign led_link[p] = link_q;
    assign led_act[p]  = act_q;
  end

endmodule

// File: tb/tb_eth_link_activity_led.sv
// tb/tb_eth_link_activity_led.sv - directed bench for eth_link_activity_led
// BLINK=4, DEBOUNCE=8, FAULT_HALF=16; outputs sampled on the falling edge.
module tb_eth_link_activity_led;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] link_up;
  logic [1:0] remote_fault;
  logic [1:0] rx_activity;
  logic [1:0] tx_activity;
  logic       lamp_test;
  logic [1:0] led_link;
  logic [1:0] led_act;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  // Counts rising edges since reset release, used to predict the fault flash phase.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  eth_link_activity_led #(
    .NUM_PORTS        (2),
    .BLINK_CYCLES     (4),
    .DEBOUNCE_CYCLES  (8),
    .FAULT_HALF_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .link_up     (link_up),
    .remote_fault(remote_fault),
    .rx_activity (rx_activity),
    .tx_activity (tx_activity),
    .lamp_test   (lamp_test),
    .led_link    (led_link),
    .led_act     (led_act)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; lamp_test = 1'b1; link_up = 2'b11;
    remote_fault = 2'b00; rx_activity = 2'b11; tx_activity = 2'b00;
    repeat (3) tick();
    n_cmp++;
    if ({led_link, led_act} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_leds: got %b want 0000", {led_link, led_act});
    end
    lamp_test = 1'b0; link_up = 2'b00; rx_activity = 2'b00;
    tick();
    n_cmp++;
    if ({led_link, led_act} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 0000", {led_link, led_act});
    end
    rst = 1'b0;
  endtask

  task automatic test_debounce();
    logic [3:0] want;
    link_up[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      want = {1'b0, (k >= 10), 2'b00};
      n_cmp++;
      if ({led_link, led_act} !== want) begin
        n_fail++;
        $display("FAIL debounce k=%0d: got %b want %b", k, {led_link, led_act}, want);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] want;
    link_up[0] = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      want = (k == 1) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if ({led_link, led_act} !== want) begin
        n_fail++;
        $display("FAIL link_drop k=%0d: got %b want %b", k, {led_link, led_act}, want);
      end
    end
    for (int k = 1; k <= 18; k++) begin
      link_up[0] = (k != 6);
      tick();
      want = {1'b0, (k >= 16), 2'b00};
      n_cmp++;
      if ({led_link, led_act} !== want) begin
        n_fail++;
        $display("FAIL glitch k=%0d: got %b want %b", k, {led_link, led_act}, want);
      end
    end
  endtask

  task automatic test_single_blink();
    logic [3:0] want;
    for (int s = 0; s < 2; s++) begin
      for (int k = 1; k <= 12; k++) begin
        if (k == 1) begin
          rx_activity[0] = 1'b1;
          tx_activity[0] = (s == 1);
        end
        tick();
        rx_activity = 2'b00; tx_activity = 2'b00;
        want = {2'b01, 1'b0, (k >= 2 && k <= 5)};
        n_cmp++;
        if ({led_link, led_act} !== want) begin
          n_fail++;
          $display("FAIL blink s=%0d k=%0d: got %b want %b", s, k, {led_link, led_act}, want);
        end
      end
    end
  endtask

  task automatic test_pending_coalesce();
    logic [3:0] want;
    logic       pulse;
    for (int s = 0; s < 3; s++) begin
      for (int k = 1; k <= 20; k++) begin
        pulse = (k == 1) ||
                (s == 0 && ((k >= 2 && k <= 4) || k == 9)) ||
                (s == 1 && k == 9) ||
                (s == 2 && k == 6);
        tx_activity[0] = pulse;
        tick();
        tx_activity = 2'b00;
        want = {2'b01, 1'b0, ((k >= 2 && k <= 5) || (k >= 10 && k <= 13))};
        n_cmp++;
        if ({led_link, led_act} !== want) begin
          n_fail++;
          $display("FAIL coalesce s=%0d k=%0d: got %b want %b", s, k, {led_link, led_act}, want);
        end
      end
    end
  endtask

  task automatic test_link_loss();
    logic [3:0] want;
    for (int k = 1; k <= 4; k++) begin
      rx_activity[0] = (k <= 2);
      link_up[0]     = (k <= 2);
      tick();
      rx_activity = 2'b00;
      case (k)
        1:       want = 4'b0100;
        2, 3:    want = 4'b0101;
        default: want = 4'b0000;
      endcase
      n_cmp++;
      if ({led_link, led_act} !== want) begin
        n_fail++;
        $display("FAIL link_loss k=%0d: got %b want %b", k, {led_link, led_act}, want);
      end
    end
    link_up[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      want = {1'b0, (k >= 10), 2'b00};
      n_cmp++;
      if ({led_link, led_act} !== want) begin
        n_fail++;
        $display("FAIL relink k=%0d: got %b want %b", k, {led_link, led_act}, want);
      end
    end
  endtask

  task automatic test_fault_lamp();
    logic [3:0] want;
    logic       ph;
    link_up[1] = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if ({led_link, led_act} !== 4'b1100) begin
      n_fail++;
      $display("FAIL port1_link: got %b want 1100", {led_link, led_act});
    end
    remote_fault[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      ph = 1'(((cyc - 1) / 16) % 2);
      want = {ph, 1'b1, 2'b00};
      n_cmp++;
      if ({led_link, led_act} !== want) begin
        n_fail++;
        $display("FAIL fault k=%0d: got %b want %b", k, {led_link, led_act}, want);
      end
    end
    for (int k = 1; k <= 25; k++) begin
      lamp_test      = (k <= 3);
      rx_activity[0] = (k == 1);
      tick();
      rx_activity = 2'b00;
      ph = 1'(((cyc - 1) / 16) % 2);
      if (k <= 3) want = 4'b1111;
      else        want = {ph, 1'b1, 1'b0, (k == 4 || k == 5)};
      n_cmp++;
      if ({led_link, led_act} !== want) begin
        n_fail++;
        $display("FAIL lamp k=%0d: got %b want %b", k, {led_link, led_act}, want);
      end
    end
    remote_fault[1] = 1'b0;
    tick();
    n_cmp++;
    if ({led_link, led_act} !== 4'b1100) begin
      n_fail++;
      $display("FAIL fault_clear: got %b want 1100", {led_link, led_act});
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    rx_activity[0] = 1'b1;
    tx_activity[1] = 1'b1;
    tick();
    rx_activity = 2'b00; tx_activity = 2'b00;
    tick();
    n_cmp++;
    if ({led_link, led_act} !== 4'b1111) begin
      n_fail++;
      $display("FAIL pre_reset_blink: got %b want 1111", {led_link, led_act});
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({led_link, led_act} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset: got %b want 0000", {led_link, led_act});
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      want = {(k >= 10), (k >= 10), 2'b00};
      n_cmp++;
      if ({led_link, led_act} !== want) begin
        n_fail++;
        $display("FAIL post_reset k=%0d: got %b want %b", k, {led_link, led_act}, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_single_blink();
    test_pending_coalesce();
    test_link_loss();
    test_fault_lamp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
